// File: rtl/peridot_i2c_avmbridge.sv
// peridot_i2c_avmbridge
// I2C slave transaction controller placed after the peridot_i2c_serial byte
// serializer. It decodes the 7-bit device address, keeps an 8-bit register
// pointer, and turns I2C register writes/reads into single-beat 8-bit
// Avalon-MM master transfers. SCL is stretched in the ACK slot while an
// Avalon transfer is outstanding.
//
// Ports
//   clk, reset_n                 system clock, async active-low reset
//   condi_start / condi_stop     start (or repeated start) / stop pulses
//   done_byte, recieve_bytedata  byte received pulse and its data
//   done_ack, recieve_ackdata    ACK slot finished pulse and sampled ACK (1 = ACK)
//   ackwaitrequest               hold SCL low in the ACK slot
//   send_ackdata                 slave drives ACK in the next ACK slot
//   send_bytedata/_valid         byte the serializer loads at done_ack
//   avm_*                        Avalon-MM master (8-bit address and data)

module peridot_i2c_avmbridge #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h55
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       condi_start,
    input  logic       condi_stop,
    input  logic       done_byte,
    input  logic       done_ack,
    input  logic [7:0] recieve_bytedata,
    input  logic       recieve_ackdata,
    output logic       ackwaitrequest,
    output logic       send_ackdata,
    output logic [7:0] send_bytedata,
    output logic       send_bytedatavalid,
    output logic [7:0] avm_address,
    output logic       avm_write,
    output logic [7:0] avm_writedata,
    output logic       avm_read,
    input  logic [7:0] avm_readdata,
    input  logic       avm_waitrequest
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PTR,
        WRITE,
        READ,
        IGNORE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pointer;

    logic       bus_done;
    logic       ack_load;
    logic       ack_value;
    logic       valid_clear;
    logic       ptr_load;
    logic       ptr_inc;
    logic       begin_read;
    logic       begin_write;
    logic       abort_stretch;
    logic [7:0] read_address;

    // A transfer finishes in the first cycle the slave drops waitrequest.
    assign bus_done = (avm_read | avm_write) & ~avm_waitrequest;

    // In READ the next fetch targets the incremented pointer, which is
    // written in the same clock as the request.
    assign read_address = (state == READ) ? (pointer + 8'd1) : pointer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Event decode: start > stop > done_byte > done_ack.
    always_comb begin
        state_next    = state;
        ack_load      = 1'b0;
        ack_value     = 1'b0;
        valid_clear   = 1'b0;
        ptr_load      = 1'b0;
        ptr_inc       = 1'b0;
        begin_read    = 1'b0;
        begin_write   = 1'b0;
        abort_stretch = 1'b0;

        if (condi_start) begin
            state_next    = ADDR;
            abort_stretch = 1'b1;
        end else if (condi_stop) begin
            state_next    = IDLE;
            abort_stretch = 1'b1;
            ack_load      = 1'b1;
            valid_clear   = 1'b1;
        end else if (done_byte) begin
            unique case (state)
                ADDR: begin
                    ack_load = 1'b1;
                    if (recieve_bytedata[7:1] == DEVICE_ADDRESS) begin
                        ack_value = 1'b1;
                        if (recieve_bytedata[0]) begin
                            begin_read = 1'b1;
                            state_next = READ;
                        end else begin
                            state_next = PTR;
                        end
                    end else begin
                        valid_clear = 1'b1;
                        state_next  = IGNORE;
                    end
                end
                PTR: begin
                    ptr_load   = 1'b1;
                    ack_load   = 1'b1;
                    ack_value  = 1'b1;
                    state_next = WRITE;
                end
                WRITE: begin
                    begin_write = 1'b1;
                    ack_load    = 1'b1;
                    ack_value   = 1'b1;
                end
                READ: begin
                    // The master's ACK is not known yet, so always prefetch.
                    ptr_inc    = 1'b1;
                    begin_read = 1'b1;
                    ack_load   = 1'b1;
                end
                IGNORE: begin
                    ack_load    = 1'b1;
                    valid_clear = 1'b1;
                end
                default: begin
                end
            endcase
        end else if (done_ack) begin
            if (state == READ && !recieve_ackdata) begin
                state_next  = IGNORE;
                ack_load    = 1'b1;
                valid_clear = 1'b1;
            end
        end
    end

    // Bus cycle and serializer handshake registers. Later assignments in the
    // block override earlier ones, so an event in the completion cycle wins
    // over the completion's own updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pointer            <= 8'h00;
            ackwaitrequest     <= 1'b0;
            send_ackdata       <= 1'b0;
            send_bytedata      <= 8'h00;
            send_bytedatavalid <= 1'b0;
            avm_address        <= 8'h00;
            avm_write          <= 1'b0;
            avm_writedata      <= 8'h00;
            avm_read           <= 1'b0;
        end else begin
            if (bus_done) begin
                avm_read       <= 1'b0;
                avm_write      <= 1'b0;
                ackwaitrequest <= 1'b0;
                if (avm_read) begin
                    send_bytedata <= avm_readdata;
                    // Data arriving after a stop/start is not offered to the master.
                    if (state_next == READ) begin
                        send_bytedatavalid <= 1'b1;
                    end
                end
                if (avm_write) begin
                    pointer <= pointer + 8'd1;
                end
            end
            // Start/stop releases SCL at once; the Avalon cycle still completes.
            if (abort_stretch) begin
                ackwaitrequest <= 1'b0;
            end
            if (ack_load) begin
                send_ackdata <= ack_value;
            end
            if (valid_clear) begin
                send_bytedatavalid <= 1'b0;
            end
            if (ptr_load) begin
                pointer <= recieve_bytedata;
            end
            if (ptr_inc) begin
                pointer <= pointer + 8'd1;
            end
            if (begin_read) begin
                avm_read       <= 1'b1;
                ackwaitrequest <= 1'b1;
                avm_address    <= read_address;
            end
            if (begin_write) begin
                avm_write      <= 1'b1;
                ackwaitrequest <= 1'b1;
                avm_address    <= pointer;
                avm_writedata  <= recieve_bytedata;
            end
        end
    end

endmodule

// File: tb/tb_peridot_i2c_avmbridge.sv
// tb_peridot_i2c_avmbridge
// Emulates the byte serializer (start/stop/byte/ack pulses) and an Avalon
// slave memory with a programmable waitrequest length. Expected Avalon
// transfers are queued when a scenario drives stimulus and are checked when
// the bridge raises a request; expected transmit bytes are queued and checked
// when the serializer would load them at done_ack.

module tb_peridot_i2c_avmbridge;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       condi_start = 1'b0;
    logic       condi_stop = 1'b0;
    logic       done_byte = 1'b0;
    logic       done_ack = 1'b0;
    logic [7:0] recieve_bytedata = 8'h00;
    logic       recieve_ackdata = 1'b0;
    logic       ackwaitrequest;
    logic       send_ackdata;
    logic [7:0] send_bytedata;
    logic       send_bytedatavalid;
    logic [7:0] avm_address;
    logic       avm_write;
    logic [7:0] avm_writedata;
    logic       avm_read;
    logic [7:0] avm_readdata = 8'h00;
    logic       avm_waitrequest = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } avm_txn_t;

    avm_txn_t   avm_q[$];
    logic [7:0] send_q[$];
    avm_txn_t   exp_t;

    logic [7:0] mem [256];
    int         wait_cfg = 0;
    int         wait_left = 0;
    logic       in_txn = 1'b0;
    logic [7:0] txn_addr = 8'h00;

    int         last_stretch;
    logic       last_ack;

    peridot_i2c_avmbridge #(.DEVICE_ADDRESS(7'h55)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .condi_start        (condi_start),
        .condi_stop         (condi_stop),
        .done_byte          (done_byte),
        .done_ack           (done_ack),
        .recieve_bytedata   (recieve_bytedata),
        .recieve_ackdata    (recieve_ackdata),
        .ackwaitrequest     (ackwaitrequest),
        .send_ackdata       (send_ackdata),
        .send_bytedata      (send_bytedata),
        .send_bytedatavalid (send_bytedatavalid),
        .avm_address        (avm_address),
        .avm_write          (avm_write),
        .avm_writedata      (avm_writedata),
        .avm_read           (avm_read),
        .avm_readdata       (avm_readdata),
        .avm_waitrequest    (avm_waitrequest)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Avalon slave memory: checks each new request against the scoreboard and
    // holds waitrequest high for wait_cfg cycles before completing it.
    always @(negedge clk) begin
        if (avm_read || avm_write) begin
            if (!in_txn) begin
                in_txn    = 1'b1;
                wait_left = wait_cfg;
                txn_addr  = avm_address;
                total++;
                if (avm_q.size() == 0) begin
                    bad++;
                    $display("FAIL avm_unexpected: got wr=%0b addr=%h data=%h, expected no transfer",
                             avm_write, avm_address, avm_writedata);
                end else begin
                    exp_t = avm_q.pop_front();
                    if (exp_t.wr !== avm_write || exp_t.wr === avm_read || exp_t.addr !== avm_address ||
                        (exp_t.wr && exp_t.data !== avm_writedata)) begin
                        bad++;
                        $display("FAIL avm_txn: got wr=%0b rd=%0b addr=%h data=%h, expected wr=%0b addr=%h data=%h",
                                 avm_write, avm_read, avm_address, avm_writedata, exp_t.wr, exp_t.addr, exp_t.data);
                    end
                end
            end else begin
                total++;
                if (avm_address !== txn_addr) begin
                    bad++;
                    $display("FAIL avm_addr_stable: got %h, expected %h", avm_address, txn_addr);
                end
            end
            if (wait_left > 0) begin
                avm_waitrequest = 1'b1;
                wait_left--;
            end else begin
                avm_waitrequest = 1'b0;
                if (avm_read) avm_readdata = mem[avm_address];
                else mem[avm_address] = avm_writedata;
                in_txn = 1'b0;
            end
        end else begin
            in_txn          = 1'b0;
            avm_waitrequest = 1'b0;
        end
    end

    task automatic pulse_start();
        @(negedge clk); condi_start = 1'b1;
        @(negedge clk); condi_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); condi_stop = 1'b1;
        @(negedge clk); condi_stop = 1'b0;
    endtask

    // Byte received, then wait out any SCL stretch; records stretch length and ACK.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); recieve_bytedata = b; done_byte = 1'b1;
        @(negedge clk); done_byte = 1'b0;
        last_stretch = 0;
        while (ackwaitrequest === 1'b1 && last_stretch < 1000) begin
            last_stretch++;
            @(negedge clk);
        end
        last_ack = send_ackdata;
    endtask

    task automatic ack_slot(input logic a);
        @(negedge clk); recieve_ackdata = a; done_ack = 1'b1;
        @(negedge clk); done_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++;
        if ({ackwaitrequest, send_ackdata, send_bytedata, send_bytedatavalid,
             avm_address, avm_write, avm_writedata, avm_read} !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {ackwaitrequest, send_ackdata, send_bytedata, send_bytedatavalid,
                      avm_address, avm_write, avm_writedata, avm_read});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0 || ackwaitrequest !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got rd=%0b wr=%0b aw=%0b, expected 0 0 0", avm_read, avm_write, ackwaitrequest);
        end
    endtask

    task automatic test_write();
        logic [7:0] b [4] = '{8'hAA, 8'h10, 8'h3C, 8'h5A};
        int         st [4] = '{0, 0, 1, 1};
        logic [7:0] exp;
        avm_q.push_back('{1'b1, 8'h10, 8'h3C});
        avm_q.push_back('{1'b1, 8'h11, 8'h5A});
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(b[i]);
            total++;
            if (last_ack !== 1'b1 || last_stretch != st[i]) begin
                bad++;
                $display("FAIL write_byte%0d: got ack=%0b stretch=%0d, expected ack=1 stretch=%0d", i, last_ack, last_stretch, st[i]);
            end
            ack_slot(1'b1);
        end
        pulse_stop();
        total++;
        if (avm_q.size() != 0 || send_bytedatavalid !== 1'b0) begin
            bad++;
            $display("FAIL write_done: got pending=%0d valid=%0b, expected 0 0", avm_q.size(), send_bytedatavalid);
        end
        // Pointer should now be 0x12: read it back (0x13 is the prefetch).
        avm_q.push_back('{1'b0, 8'h12, 8'h00});
        avm_q.push_back('{1'b0, 8'h13, 8'h00});
        send_q.push_back(8'h12 ^ 8'h5A);
        pulse_start();
        send_byte(8'hAB);
        exp = send_q.pop_front();
        total++;
        if (send_bytedata !== exp || send_bytedatavalid !== 1'b1 || last_ack !== 1'b1) begin
            bad++;
            $display("FAIL write_ptr_end: got data=%h valid=%0b ack=%0b, expected data=%h valid=1 ack=1",
                     send_bytedata, send_bytedatavalid, last_ack, exp);
        end
        ack_slot(1'b1);
        send_byte(8'h00);
        ack_slot(1'b0);
        pulse_stop();
        total++;
        if (avm_q.size() != 0) begin
            bad++;
            $display("FAIL write_ptr_reads: got pending=%0d, expected 0", avm_q.size());
        end
    endtask

    task automatic test_read();
        logic [7:0] exp;
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h23] = 8'h44;
        for (int a = 8'h20; a <= 8'h23; a++) avm_q.push_back('{1'b0, 8'(a), 8'h00});
        send_q.push_back(8'h11); send_q.push_back(8'h22); send_q.push_back(8'h33);
        pulse_start();
        send_byte(8'hAA); ack_slot(1'b1);
        send_byte(8'h20); ack_slot(1'b1);
        pulse_start();
        send_byte(8'hAB);
        total++;
        if (last_ack !== 1'b1 || last_stretch != 1) begin
            bad++;
            $display("FAIL read_addr: got ack=%0b stretch=%0d, expected ack=1 stretch=1", last_ack, last_stretch);
        end
        for (int i = 0; i < 3; i++) begin
            exp = send_q.pop_front();
            total++;
            if (send_bytedata !== exp || send_bytedatavalid !== 1'b1) begin
                bad++;
                $display("FAIL read_byte%0d: got data=%h valid=%0b, expected data=%h valid=1",
                         i, send_bytedata, send_bytedatavalid, exp);
            end
            ack_slot(1'b1);
            send_byte(8'hFF);
            total++;
            if (last_ack !== 1'b0 || last_stretch != 1) begin
                bad++;
                $display("FAIL read_slot%0d: got ack=%0b stretch=%0d, expected ack=0 stretch=1", i, last_ack, last_stretch);
            end
        end
        ack_slot(1'b0);
        total++;
        if (send_bytedatavalid !== 1'b0) begin
            bad++;
            $display("FAIL read_nack_valid: got %0b, expected 0", send_bytedatavalid);
        end
        pulse_stop();
        // Pointer should be 0x23.
        avm_q.push_back('{1'b0, 8'h23, 8'h00});
        avm_q.push_back('{1'b0, 8'h24, 8'h00});
        pulse_start();
        send_byte(8'hAB);
        total++;
        if (send_bytedata !== 8'h44) begin
            bad++;
            $display("FAIL read_ptr_end: got %h, expected 44", send_bytedata);
        end
        ack_slot(1'b1);
        send_byte(8'hFF);
        ack_slot(1'b0);
        pulse_stop();
        total++;
        if (avm_q.size() != 0) begin
            bad++;
            $display("FAIL read_pending: got %0d, expected 0", avm_q.size());
        end
    endtask

    task automatic test_mismatch();
        pulse_start();
        send_byte(8'h54);
        total++;
        if (last_ack !== 1'b0 || last_stretch != 0) begin
            bad++;
            $display("FAIL mismatch_addr: got ack=%0b stretch=%0d, expected ack=0 stretch=0", last_ack, last_stretch);
        end
        ack_slot(1'b0);
        send_byte(8'h01);
        total++;
        if (last_ack !== 1'b0 || last_stretch != 0 || send_bytedatavalid !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_data: got ack=%0b stretch=%0d valid=%0b, expected 0 0 0",
                     last_ack, last_stretch, send_bytedatavalid);
        end
        ack_slot(1'b0);
        pulse_stop();
    endtask

    task automatic test_stretch();
        avm_q.push_back('{1'b1, 8'h40, 8'h77});
        pulse_start();
        send_byte(8'hAA); ack_slot(1'b1);
        send_byte(8'h40); ack_slot(1'b1);
        wait_cfg = 50;
        send_byte(8'h77);
        wait_cfg = 0;
        total++;
        if (last_stretch != 51 || last_ack !== 1'b1) begin
            bad++;
            $display("FAIL stretch_len: got stretch=%0d ack=%0b, expected stretch=51 ack=1", last_stretch, last_ack);
        end
        ack_slot(1'b1);
        pulse_stop();
        total++;
        if (avm_q.size() != 0 || mem[8'h40] !== 8'h77) begin
            bad++;
            $display("FAIL stretch_write: got pending=%0d mem=%h, expected 0 77", avm_q.size(), mem[8'h40]);
        end
    endtask

    task automatic test_wrap();
        avm_q.push_back('{1'b1, 8'hFF, 8'hD1});
        avm_q.push_back('{1'b1, 8'h00, 8'hD2});
        pulse_start();
        send_byte(8'hAA); ack_slot(1'b1);
        send_byte(8'hFF); ack_slot(1'b1);
        send_byte(8'hD1); ack_slot(1'b1);
        send_byte(8'hD2); ack_slot(1'b1);
        pulse_stop();
        total++;
        if (avm_q.size() != 0 || mem[8'hFF] !== 8'hD1 || mem[8'h00] !== 8'hD2) begin
            bad++;
            $display("FAIL wrap: got pending=%0d ff=%h 00=%h, expected 0 d1 d2", avm_q.size(), mem[8'hFF], mem[8'h00]);
        end
    endtask

    task automatic test_abort();
        int n;
        avm_q.push_back('{1'b0, 8'h30, 8'h00});
        pulse_start();
        send_byte(8'hAA); ack_slot(1'b1);
        send_byte(8'h30); ack_slot(1'b1);
        pulse_start();
        wait_cfg = 20;
        @(negedge clk); recieve_bytedata = 8'hAB; done_byte = 1'b1;
        @(negedge clk); done_byte = 1'b0;
        total++;
        if (ackwaitrequest !== 1'b1 || avm_read !== 1'b1) begin
            bad++;
            $display("FAIL abort_begin: got aw=%0b rd=%0b, expected 1 1", ackwaitrequest, avm_read);
        end
        repeat (3) @(negedge clk);
        condi_stop = 1'b1;
        @(negedge clk); condi_stop = 1'b0;
        total++;
        if (ackwaitrequest !== 1'b0 || avm_read !== 1'b1) begin
            bad++;
            $display("FAIL abort_release: got aw=%0b rd=%0b, expected aw=0 rd=1", ackwaitrequest, avm_read);
        end
        n = 0;
        while (avm_read === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        wait_cfg = 0;
        total++;
        if (n >= 100 || send_bytedatavalid !== 1'b0 || send_ackdata !== 1'b0) begin
            bad++;
            $display("FAIL abort_end: got cycles=%0d valid=%0b ack=%0b, expected <100 0 0", n, send_bytedatavalid, send_ackdata);
        end
        // Idle bridge ignores a byte without a start.
        send_byte(8'hAA);
        total++;
        if (last_ack !== 1'b0 || last_stretch != 0 || avm_q.size() != 0) begin
            bad++;
            $display("FAIL abort_idle: got ack=%0b stretch=%0d pending=%0d, expected 0 0 0", last_ack, last_stretch, avm_q.size());
        end
    endtask

    task automatic test_reset_abort();
        avm_q.push_back('{1'b1, 8'h50, 8'h66});
        pulse_start();
        send_byte(8'hAA); ack_slot(1'b1);
        send_byte(8'h50); ack_slot(1'b1);
        wait_cfg = 10;
        @(negedge clk); recieve_bytedata = 8'h66; done_byte = 1'b1;
        @(negedge clk); done_byte = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (ackwaitrequest !== 1'b0 || avm_write !== 1'b0 || send_ackdata !== 1'b0 || avm_address !== 8'h00) begin
            bad++;
            $display("FAIL reset_abort: got aw=%0b wr=%0b ack=%0b addr=%h, expected 0 0 0 00",
                     ackwaitrequest, avm_write, send_ackdata, avm_address);
        end
        @(negedge clk); reset_n = 1'b1;
        wait_cfg = 0;
        // Pointer must be back at 0x00 (mem[00] was written by the wrap test).
        avm_q.push_back('{1'b0, 8'h00, 8'h00});
        pulse_start();
        send_byte(8'hAB);
        total++;
        if (send_bytedata !== 8'hD2 || mem[8'h50] !== (8'h50 ^ 8'h5A)) begin
            bad++;
            $display("FAIL reset_pointer: got data=%h mem50=%h, expected d2 %h", send_bytedata, mem[8'h50], 8'h50 ^ 8'h5A);
        end
        pulse_stop();
        total++;
        if (avm_q.size() != 0) begin
            bad++;
            $display("FAIL reset_pending: got %0d, expected 0", avm_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_stretch();
        test_wrap();
        test_abort();
        test_reset_abort();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
